// File: rtl/sync_fifo_param_pkg.sv
// Shared FIFO definitions: default geometry and a constant ceil-log2 helper.
package fifo_pkg;

  localparam int unsigned FIFO_W_DEF = 8;
  localparam int unsigned FIFO_D_DEF = 32;

  // Smallest r with 2**r >= n; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer-side signal bundle of sync_fifo_param.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_W_DEF,
  parameter int unsigned DEPTH = FIFO_D_DEF
);

  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] io_dataIn;
  logic             io_write;
  logic             io_read;
  logic             io_clearErr;
  logic [WIDTH-1:0] io_dataOut;
  logic             io_full;
  logic             io_empty;
  logic             io_almostFull;
  logic             io_almostEmpty;
  logic [CW-1:0]    io_count;
  logic             io_overflow;
  logic             io_underflow;

  modport master (
    output io_dataIn, io_write, io_read, io_clearErr,
    input  io_dataOut, io_full, io_empty, io_almostFull, io_almostEmpty, io_count,
           io_overflow, io_underflow
  );

  modport slave (
    input  io_dataIn, io_write, io_read, io_clearErr,
    output io_dataOut, io_full, io_empty, io_almostFull, io_almostEmpty, io_count,
           io_overflow, io_underflow
  );

endinterface

// File: rtl/sync_fifo_param_mem.sv
// Register-array storage: synchronous write port, asynchronous read port.
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_W_DEF,
  parameter int unsigned DEPTH = FIFO_D_DEF
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, almost flags and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = FIFO_W_DEF,
  parameter int unsigned DEPTH        = FIFO_D_DEF,
  parameter int unsigned AFULL_LEVEL  = 28,
  parameter int unsigned AEMPTY_LEVEL = 4
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned CW = clog2(DEPTH + 1);
  // Pointers only need to address DEPTH entries; they wrap explicitly at DEPTH-1.
  localparam int unsigned PW = clog2(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be >= 2");
  end
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $fatal(1, "sync_fifo_param: AFULL_LEVEL must be in 1..DEPTH");
  end
  if (AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
    $fatal(1, "sync_fifo_param: AEMPTY_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             full, empty, wr_en, rd_en;
  logic [WIDTH-1:0] rdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = bus.io_write & ~full;
  assign rd_en = bus.io_read & ~empty;

  always_comb begin
    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as a clear keeps the flag set.
    ovf_d = (bus.io_write & full) | (ovf_q & ~bus.io_clearErr);
    unf_d = (bus.io_read & empty) | (unf_q & ~bus.io_clearErr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (bus.io_dataIn),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign bus.io_dataOut     = empty ? '0 : rdata;
  assign bus.io_full        = full;
  assign bus.io_empty       = empty;
  assign bus.io_almostFull  = (count_q >= CW'(AFULL_LEVEL));
  assign bus.io_almostEmpty = (count_q <= CW'(AEMPTY_LEVEL));
  assign bus.io_count       = count_q;
  assign bus.io_overflow    = ovf_q;
  assign bus.io_underflow   = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a 32-deep and a 5-deep instance checked against queue models.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned dep[2] = '{32, 5};
  int unsigned afl[2] = '{28, 4};
  int unsigned ael[2] = '{4, 1};

  logic       w[2], r[2], c[2];
  logic [7:0] d[2];

  logic [7:0] o_dout[2], o_cnt[2];
  logic       o_full[2], o_empty[2], o_af[2], o_ae[2], o_ovf[2], o_unf[2];

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(32)) bus32 ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(5))  bus5 ();

  assign bus32.io_write   = w[0];
  assign bus32.io_read    = r[0];
  assign bus32.io_clearErr = c[0];
  assign bus32.io_dataIn  = d[0];
  assign bus5.io_write    = w[1];
  assign bus5.io_read     = r[1];
  assign bus5.io_clearErr = c[1];
  assign bus5.io_dataIn   = d[1];

  assign o_dout[0] = bus32.io_dataOut;
  assign o_cnt[0]  = 8'(bus32.io_count);
  assign o_full[0] = bus32.io_full;
  assign o_empty[0] = bus32.io_empty;
  assign o_af[0]   = bus32.io_almostFull;
  assign o_ae[0]   = bus32.io_almostEmpty;
  assign o_ovf[0]  = bus32.io_overflow;
  assign o_unf[0]  = bus32.io_underflow;
  assign o_dout[1] = bus5.io_dataOut;
  assign o_cnt[1]  = 8'(bus5.io_count);
  assign o_full[1] = bus5.io_full;
  assign o_empty[1] = bus5.io_empty;
  assign o_af[1]   = bus5.io_almostFull;
  assign o_ae[1]   = bus5.io_almostEmpty;
  assign o_ovf[1]  = bus5.io_overflow;
  assign o_unf[1]  = bus5.io_underflow;

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(32), .AFULL_LEVEL(28), .AEMPTY_LEVEL(4)
  ) dut32 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus32)
  );

  sync_fifo_param #(
    .WIDTH(8), .DEPTH(5), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)
  ) dut5 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus5)
  );

  // Reference model: a queue of held words plus the two sticky error bits.
  logic [7:0] mq[2][$];
  bit         m_ovf[2], m_unf[2];

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit wr; bit rd; bit clr; logic [7:0] din;
    int cnt; logic [7:0] dout;
    bit full; bit empty; bit af; bit ae; bit ovf; bit unf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    int n;
    bit full, empty;
    n = mq[i].size();
    full = (n == int'(dep[i]));
    empty = (n == 0);
    if (rst) begin
      mq[i].delete();
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end else begin
      m_ovf[i] = (w[i] && full) || (m_ovf[i] && !c[i]);
      m_unf[i] = (r[i] && empty) || (m_unf[i] && !c[i]);
      if (r[i] && !empty) void'(mq[i].pop_front());
      if (w[i] && !full) mq[i].push_back(d[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      w[i] = 1'b0; r[i] = 1'b0; c[i] = 1'b0; d[i] = 8'h00;
    end
  endtask

  task automatic check_inst(input int i, input string tag);
    int n;
    n = mq[i].size();
    chk({tag, "_count"}, o_cnt[i], n);
    chk({tag, "_dout"}, o_dout[i], (n > 0) ? mq[i][0] : 8'h00);
    chk({tag, "_full"}, o_full[i], n == int'(dep[i]));
    chk({tag, "_empty"}, o_empty[i], n == 0);
    chk({tag, "_afull"}, o_af[i], n >= int'(afl[i]));
    chk({tag, "_aempty"}, o_ae[i], n <= int'(ael[i]));
    chk({tag, "_ovf"}, o_ovf[i], m_ovf[i]);
    chk({tag, "_unf"}, o_unf[i], m_unf[i]);
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 1};
    tbl[1]  = '{0, 0, 1, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 0, 8'hA1, 1, 8'hA1, 0, 0, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 0, 8'hA2, 2, 8'hA1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 8'hA3, 3, 8'hA1, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 8'hA4, 4, 8'hA1, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 8'hA5, 5, 8'hA1, 1, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 8'hA6, 5, 8'hA1, 1, 0, 1, 0, 1, 0};
    tbl[8]  = '{1, 1, 0, 8'hA7, 4, 8'hA2, 0, 0, 1, 0, 1, 0};
    tbl[9]  = '{1, 0, 1, 8'hA8, 5, 8'hA2, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 8'h00, 4, 8'hA3, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 8'h00, 3, 8'hA4, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 0, 8'hA9, 3, 8'hA5, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 8'h00, 2, 8'hA8, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 0, 8'h00, 1, 8'hA9, 0, 0, 0, 1, 0, 0};
    tbl[15] = '{0, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 0};
    tbl[16] = '{1, 1, 0, 8'hAA, 1, 8'hAA, 0, 0, 0, 1, 0, 1};

    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset then idle.
    tick();
    chk("rst_empty", o_empty[0], 1);
    chk("rst_aempty", o_ae[0], 1);
    chk("rst_count", o_cnt[0], 0);
    chk("rst_dout", o_dout[0], 0);
    chk("rst_ovf", o_ovf[0], 0);
    chk("rst_unf", o_unf[0], 0);
    chk("rst_full", o_full[0], 0);
    chk("rst_afull", o_af[0], 0);

    // Fill 32 deep with 0x01..0x20, then one write too many.
    for (int k = 1; k <= 32; k++) begin
      w[0] = 1'b1; d[0] = 8'(k);
      tick();
      chk("fill_afull", o_af[0], k >= 28);
      chk("fill_count", o_cnt[0], k);
      check_inst(0, "fill");
    end
    chk("fill_full", o_full[0], 1);
    d[0] = 8'h21;
    tick();
    w[0] = 1'b0;
    chk("over_ovf", o_ovf[0], 1);
    chk("over_head", o_dout[0], 8'h01);
    chk("over_count", o_cnt[0], 32);

    // Drain in order, then one read too many.
    for (int k = 1; k <= 32; k++) begin
      chk("drain_data", o_dout[0], k);
      r[0] = 1'b1;
      tick();
      check_inst(0, "drain");
    end
    chk("drain_empty", o_empty[0], 1);
    tick();
    r[0] = 1'b0;
    chk("under_unf", o_unf[0], 1);
    chk("under_count", o_cnt[0], 0);
    c[0] = 1'b1;
    tick();
    c[0] = 1'b0;
    chk("clr_ovf", o_ovf[0], 0);
    chk("clr_unf", o_unf[0], 0);

    // Full with simultaneous read and write: read wins, write is dropped.
    for (int k = 1; k <= 32; k++) begin
      w[0] = 1'b1; d[0] = 8'(8'h40 + k);
      tick();
    end
    r[0] = 1'b1; d[0] = 8'hEE;
    tick();
    chk("fullrw_count", o_cnt[0], 31);
    chk("fullrw_head", o_dout[0], 8'h42);
    w[0] = 1'b0;
    for (int k = 0; k < 31; k++) begin
      tick();
      check_inst(0, "fullrw_drain");
    end
    r[0] = 1'b0;
    c[0] = 1'b1;
    tick();
    c[0] = 1'b0;
    // Empty with simultaneous read and write: write is accepted.
    w[0] = 1'b1; r[0] = 1'b1; d[0] = 8'h5A;
    tick();
    w[0] = 1'b0; r[0] = 1'b0;
    chk("emptyrw_count", o_cnt[0], 1);
    chk("emptyrw_dout", o_dout[0], 8'h5A);

    // Reset with 10 entries held discards them.
    for (int k = 0; k < 9; k++) begin
      w[0] = 1'b1; d[0] = 8'(k);
      tick();
    end
    w[0] = 1'b0;
    chk("pre_rst_count", o_cnt[0], 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", o_cnt[0], 0);
    chk("midrst_empty", o_empty[0], 1);

    // Clear and overflow in the same cycle: overflow stays set.
    for (int k = 0; k < 33; k++) begin
      w[0] = 1'b1; d[0] = 8'(k);
      tick();
    end
    chk("setclr_pre", o_ovf[0], 1);
    c[0] = 1'b1;
    tick();
    chk("setclr_ovf", o_ovf[0], 1);
    w[0] = 1'b0;
    tick();
    c[0] = 1'b0;
    chk("clr_only_ovf", o_ovf[0], 0);
    check_inst(0, "setclr");

    // DEPTH=5: 12 write/read pairs at constant fill of 2, pointers wrap.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    w[1] = 1'b1; d[1] = 8'h10;
    tick();
    d[1] = 8'h11;
    tick();
    r[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      d[1] = 8'(8'h12 + k);
      tick();
      chk("pair_count", o_cnt[1], 2);
      chk("pair_head", o_dout[1], 8'(8'h11 + k));
    end
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Table-driven vectors on the 5-deep instance.
    for (int i = 0; i < 17; i++) begin
      w[1] = tbl[i].wr; r[1] = tbl[i].rd; c[1] = tbl[i].clr; d[1] = tbl[i].din;
      tick();
      chk($sformatf("tbl%0d_count", i), o_cnt[1], tbl[i].cnt);
      chk($sformatf("tbl%0d_dout", i), o_dout[1], tbl[i].dout);
      chk($sformatf("tbl%0d_full", i), o_full[1], tbl[i].full);
      chk($sformatf("tbl%0d_empty", i), o_empty[1], tbl[i].empty);
      chk($sformatf("tbl%0d_afull", i), o_af[1], tbl[i].af);
      chk($sformatf("tbl%0d_aempty", i), o_ae[1], tbl[i].ae);
      chk($sformatf("tbl%0d_ovf", i), o_ovf[1], tbl[i].ovf);
      chk($sformatf("tbl%0d_unf", i), o_unf[1], tbl[i].unf);
    end
    idle();

    // Random traffic with write-heavy and read-heavy phases.
    for (int n = 0; n < 3000; n++) begin
      int pw;
      pw = ((n / 200) % 3 == 0) ? 80 : (((n / 200) % 3 == 1) ? 20 : 50);
      for (int i = 0; i < 2; i++) begin
        w[i] = ($urandom_range(0, 99) < pw);
        r[i] = ($urandom_range(0, 99) < 100 - pw);
        c[i] = ($urandom_range(0, 29) == 0);
        d[i] = 8'($urandom);
      end
      rst = ($urandom_range(0, 599) == 0);
      tick();
      check_inst(0, "rnd32");
      check_inst(1, "rnd5");
    end
    rst = 1'b0;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
